// File: rtl/exc_sequencer_pkg.sv
// Shared encodings for the exception sequencer: cause codes, FSM states and
// the default exception vector.
package exc_sequencer_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OVF    = 2'b01,
        CAUSE_UNDEF1 = 2'b10,
        CAUSE_UNDEF2 = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ENTER   = 2'b01,
        ST_HANDLER = 2'b10,
        ST_RETURN  = 2'b11
    } state_e;

    localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_0080;

endpackage

// File: rtl/exc_prio_enc.sv
// Three-way exception priority encoder. EX overflow wins because EX holds the
// older instruction; slot 1 wins over slot 2 within the ID pair.
module exc_prio_enc
    import exc_sequencer_pkg::*;
(
    input  logic   ovf,
    input  logic   undef1,
    input  logic   undef2,
    output logic   take,
    output cause_e cause,
    output logic   sel_ex
);

    always_comb begin
        take   = ovf | undef1 | undef2;
        sel_ex = ovf;
        cause  = CAUSE_NONE;
        if (ovf)
            cause = CAUSE_OVF;
        else if (undef1)
            cause = CAUSE_UNDEF1;
        else if (undef2)
            cause = CAUSE_UNDEF2;
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer for the dual-slot pipeline. Strobes are
// decoded from the state register and latched EPC/cause only (Moore).
module exc_sequencer
    import exc_sequencer_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_ovf,
    input  logic [31:0]      ex_pc,
    input  logic             id_undef1,
    input  logic             id_undef2,
    input  logic [31:0]      id_pc,
    input  logic             eret,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic             in_handler,
    output logic             double_fault,
    output logic [CNT_W-1:0] exc_count
);

    state_e state, state_nxt;
    cause_e cause_q;
    cause_e req_cause;
    logic   req_take;
    logic   req_sel_ex;

    exc_prio_enc u_prio (
        .ovf    (ex_ovf),
        .undef1 (id_undef1),
        .undef2 (id_undef2),
        .take   (req_take),
        .cause  (req_cause),
        .sel_ex (req_sel_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        in_handler  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_take)
                    state_nxt = ST_ENTER;
            end
            ST_ENTER: begin
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                ex_flush    = (cause_q == CAUSE_OVF);
                redirect    = 1'b1;
                redirect_pc = HANDLER_ADDR;
                in_handler  = 1'b1;
                state_nxt   = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (eret)
                    state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // EPC/cause/counter only move on the IDLE->ENTER edge; cause clears leaving RETURN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc          <= 32'h0;
            cause_q      <= CAUSE_NONE;
            double_fault <= 1'b0;
            exc_count    <= '0;
        end else begin
            if (state == ST_IDLE && req_take) begin
                epc     <= req_sel_ex ? ex_pc : id_pc;
                cause_q <= req_cause;
                if (exc_count != {CNT_W{1'b1}})
                    exc_count <= exc_count + CNT_W'(1);
            end
            if (state == ST_HANDLER && req_take)
                double_fault <= 1'b1;
            if (state == ST_RETURN)
                cause_q <= CAUSE_NONE;
        end
    end

    assign cause = cause_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed plus randomized bench for exc_sequencer against a behavioural
// model of the exception phases.
module tb_exc_sequencer;

    localparam logic [31:0] HADDR = 32'h0000_0080;
    localparam int          CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ex_ovf = 1'b0, id_undef1 = 1'b0, id_undef2 = 1'b0, eret = 1'b0;
    logic [31:0]   ex_pc = '0, id_pc = '0;
    logic          if_flush, id_flush, ex_flush, redirect, in_handler, double_fault;
    logic [31:0]   redirect_pc, epc;
    logic [1:0]    cause;
    logic [CW-1:0] exc_count;

    exc_sequencer #(.HANDLER_ADDR(HADDR), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ex_ovf(ex_ovf), .ex_pc(ex_pc),
        .id_undef1(id_undef1), .id_undef2(id_undef2), .id_pc(id_pc), .eret(eret),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
        .in_handler(in_handler), .double_fault(double_fault), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model phase: "idle", "enter", "handler", "return".
    string       m_ph  = "idle";
    logic [31:0] m_epc = '0;
    int          m_cause = 0;
    bit          m_df  = 0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = "idle"; m_epc = '0; m_cause = 0; m_df = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit ovf, u1, u2, er, input logic [31:0] epv, ipv);
        bit any;
        any = ovf | u1 | u2;
        if (m_ph == "idle") begin
            if (any) begin
                m_ph = "enter";
                if (ovf)     begin m_epc = epv; m_cause = 1; end
                else if (u1) begin m_epc = ipv; m_cause = 2; end
                else         begin m_epc = ipv; m_cause = 3; end
                if (m_cnt < CMAX) m_cnt++;
            end
        end else if (m_ph == "enter") begin
            m_ph = "handler";
        end else if (m_ph == "handler") begin
            if (any) m_df = 1;
            if (er) m_ph = "return";
        end else begin
            m_cause = 0;
            m_ph = "idle";
        end
    endtask

    task automatic check_all(input string tag);
        bit ent, ret;
        ent = (m_ph == "enter");
        ret = (m_ph == "return");
        chk({tag, ".if_flush"},  {31'b0, if_flush},   {31'b0, ent | ret});
        chk({tag, ".id_flush"},  {31'b0, id_flush},   {31'b0, ent | ret});
        chk({tag, ".ex_flush"},  {31'b0, ex_flush},   {31'b0, ent && m_cause == 1});
        chk({tag, ".redirect"},  {31'b0, redirect},   {31'b0, ent | ret});
        chk({tag, ".redir_pc"},  redirect_pc,         ent ? HADDR : (ret ? m_epc : 32'h0));
        chk({tag, ".epc"},       epc,                 m_epc);
        chk({tag, ".cause"},     {30'b0, cause},      32'(m_cause));
        chk({tag, ".in_handler"},{31'b0, in_handler}, {31'b0, ent || m_ph == "handler"});
        chk({tag, ".dfault"},    {31'b0, double_fault}, {31'b0, m_df});
        chk({tag, ".exc_count"}, {24'b0, exc_count},  32'(m_cnt));
    endtask

    task automatic step(input string tag, input bit ovf, u1, u2, er,
                        input logic [31:0] epv, ipv);
        ex_ovf = ovf; id_undef1 = u1; id_undef2 = u2; eret = er;
        ex_pc = epv; id_pc = ipv;
        @(posedge clk);
        model_edge(ovf, u1, u2, er, epv, ipv);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("in_reset");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Overflow entry, then return through eret.
        step("ovf_enter", 1, 0, 0, 0, 32'h0000_1004, 32'h0);
        chk("ovf_epc_const", epc, 32'h0000_1004);
        chk("ovf_rpc_const", redirect_pc, 32'h0000_0080);
        step("ovf_hand", 0, 0, 0, 0, 32'h0, 32'h0);
        step("ovf_eret", 0, 0, 0, 1, 32'h0, 32'h0);
        chk("ret_rpc_const", redirect_pc, 32'h0000_1004);
        step("ovf_idle", 0, 0, 0, 0, 32'h0, 32'h0);
        chk("ret_cause_clr", {30'b0, cause}, 32'h0);

        // All three at once: overflow wins.
        step("prio3", 1, 1, 1, 0, 32'h0000_01FC, 32'h0000_0200);
        chk("prio3_cause", {30'b0, cause}, 32'h1);
        step("prio3_h", 0, 0, 0, 0, 32'h0, 32'h0);
        step("prio3_r", 0, 0, 0, 1, 32'h0, 32'h0);
        step("prio3_i", 0, 0, 0, 0, 32'h0, 32'h0);

        // Both slots undefined: slot 1 wins, EX not flushed.
        step("prio2", 0, 1, 1, 0, 32'h0000_01FC, 32'h0000_0200);
        chk("prio2_exfl", {31'b0, ex_flush}, 32'h0);
        step("prio2_h", 0, 0, 0, 0, 32'h0, 32'h0);

        // Nested request inside the handler, then with eret on the same edge.
        step("nest", 0, 0, 1, 0, 32'h0, 32'h0000_0444);
        chk("nest_df", {31'b0, double_fault}, 32'h1);
        step("nest_eret", 1, 0, 0, 1, 32'h0000_0888, 32'h0);
        step("nest_idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Back-to-back: slot-2 request taken, next-edge overflow dropped.
        step("b2b_1", 0, 0, 1, 0, 32'h0, 32'h0000_0ABC);
        step("b2b_2", 1, 0, 0, 0, 32'h0000_0DEF, 32'h0);
        step("b2b_h", 0, 0, 0, 1, 32'h0, 32'h0);
        step("b2b_rd", 1, 1, 1, 0, 32'h0000_0111, 32'h0000_0222);
        step("b2b_i", 0, 0, 0, 0, 32'h0, 32'h0);

        // Saturate the counter.
        for (int i = 0; i < 260; i++) begin
            step("sat_e", 1, 0, 0, 0, 32'(i * 4), 32'h0);
            step("sat_h", 0, 0, 0, 0, 32'h0, 32'h0);
            step("sat_r", 0, 0, 0, 1, 32'h0, 32'h0);
            step("sat_i", 0, 0, 0, 0, 32'h0, 32'h0);
        end
        chk("sat_const", {24'b0, exc_count}, 32'h0000_00FF);

        // Async reset during ENTER.
        step("arst_e", 1, 0, 0, 0, 32'h0000_2000, 32'h0);
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_redir", {31'b0, redirect}, 32'h0);
        check_all("arst");
        @(negedge clk) reset = 1'b1;
        step("arst_post", 0, 0, 0, 0, 32'h0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
